// File: rtl/lc3b_mem_responder_if.sv
// LC-3b CPU memory bus: request/write payload from the CPU, read data and completion from memory.
interface lc3b_mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        mem_error;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp, mem_error
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp, mem_error
  );
endinterface

// File: rtl/lc3b_mem_responder.sv
// Behavioural LC-3b main memory with programmable wait states and one-cycle mem_resp pulse.
// Optional misaligned word-access detection: define MEM_RESP_ALIGN_CHK_EN.
module lc3b_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 15,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lc3b_mem_responder_if.slave  mem
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned DW    = 16;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [1:0]            be_q, be_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  mis_q, mis_d;
  logic                  resp_q, resp_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [DW-1:0]         mem_q [DEPTH];

  logic req_c;
  logic misalign_c;
  logic unused_addr_c;

  assign req_c         = mem.mem_read | mem.mem_write;
  assign unused_addr_c = ^mem.mem_address;

`ifdef MEM_RESP_ALIGN_CHK_EN
  // A word access is any read, or a write touching both lanes.
  assign misalign_c = mem.mem_address[0] & (~mem.mem_write | (mem.mem_byte_enable == 2'b11));
`else
  assign misalign_c = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    mis_d   = mis_q;
    resp_d  = 1'b0;
    rdata_d = '0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_c) begin
          idx_d   = mem.mem_address[DEPTH_LOG2:1];
          wdata_d = mem.mem_wdata;
          be_d    = mem.mem_byte_enable;
          rd_d    = mem.mem_read;
          wr_d    = mem.mem_write;
          mis_d   = misalign_c;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!req_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are loaded on the edge entering RESP; read data is the pre-write word.
    if (state_d == RESP) begin
      resp_d = 1'b1;
      err_d  = mis_d;
      if (rd_d && !mis_d) rdata_d = mem_q[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      mis_q   <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      mis_q   <= mis_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is not reset; the write commits on the edge that ends RESP.
  always_ff @(posedge clk) begin
    if (state_q == RESP && wr_q && !mis_q) begin
      if (be_q[0]) mem_q[idx_q][7:0]  <= wdata_q[7:0];
      if (be_q[1]) mem_q[idx_q][15:8] <= wdata_q[15:8];
    end
  end

  assign mem.mem_resp  = resp_q;
  assign mem.mem_rdata = rdata_q;
  assign mem.mem_error = err_q;
endmodule
